// File: rtl/ntt_stage_sched.sv
// rtl/ntt_stage_sched.sv - in-place radix-2 NTT stage/butterfly address scheduler
// Optional NTT_STAGE_SCHED_PERF_EN adds a 32-bit busy-cycle counter output perf_cycles.
module ntt_stage_sched #(
    parameter int LOG_N    = 8,
    parameter int PIPE_LAT = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      rd_en,
    output logic [LOG_N-1:0]          rd_addr_top,
    output logic [LOG_N-1:0]          rd_addr_bot,
    output logic [LOG_N-2:0]          tw_addr,
    output logic                      wr_en,
    output logic [LOG_N-1:0]          wr_addr_top,
    output logic [LOG_N-1:0]          wr_addr_bot,
`ifdef NTT_STAGE_SCHED_PERF_EN
    output logic [31:0]               perf_cycles,
`endif
    output logic [$clog2(LOG_N):0]    stage_o
);

    localparam int SW = $clog2(LOG_N) + 1;
    localparam int JW = LOG_N - 1;
    localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [JW-1:0] J_LAST   = '1;
    localparam logic [SW-1:0] S_LAST   = SW'(LOG_N - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PIPE_LAT - 1);

    typedef enum logic [2:0] {IDLE, RUN, GAP, DRAIN, FIN} state_t;

    state_t          state;
    logic [SW-1:0]   stage;
    logic [JW-1:0]   j;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   iss_s;
    logic [JW-1:0]   iss_j;

    logic [PIPE_LAT-1:0] en_dl;
    logic [LOG_N-1:0]    top_dl [PIPE_LAT];
    logic [LOG_N-1:0]    bot_dl [PIPE_LAT];

    function automatic logic [LOG_N-1:0] low_mask(input logic [SW-1:0] s);
        return (LOG_N'(1) << s) - LOG_N'(1);
    endfunction

    function automatic logic [LOG_N-1:0] top_of(input logic [JW-1:0] jj, input logic [SW-1:0] s);
        logic [LOG_N-1:0] jx;
        jx = {1'b0, jj};
        return ((jx >> s) << (s + SW'(1))) | (jx & low_mask(s));
    endfunction

    function automatic logic [JW-1:0] tw_of(input logic [JW-1:0] jj, input logic [SW-1:0] s);
        logic [LOG_N-1:0] t;
        t = ({1'b0, jj} & low_mask(s)) << (S_LAST - s);
        return t[JW-1:0];
    endfunction

    // Butterfly coordinates for the read issued on the coming edge.
    always_comb begin
        iss_s = stage;
        iss_j = j + JW'(1);
        if (state == IDLE) begin
            iss_s = '0;
            iss_j = '0;
        end else if (state == GAP) begin
            iss_s = stage + SW'(1);
            iss_j = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            stage       <= '0;
            j           <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr_top <= '0;
            rd_addr_bot <= '0;
            tw_addr     <= '0;
            stage_o     <= '0;
        end else begin
            done  <= 1'b0;
            rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        stage <= '0;
                        j     <= '0;
                        rd_en <= 1'b1;
                    end
                end
                RUN: begin
                    if (j == J_LAST) begin
                        cnt   <= '0;
                        state <= (stage == S_LAST) ? DRAIN : GAP;
                    end else begin
                        j     <= j + JW'(1);
                        rd_en <= 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == CNT_LAST) begin
                        state <= RUN;
                        stage <= stage + SW'(1);
                        j     <= '0;
                        rd_en <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    if (cnt == CNT_LAST) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            // Addresses only move when a read is issued; they hold through GAP/DRAIN/IDLE.
            if ((state == IDLE && start) || (state == RUN && j != J_LAST) ||
                (state == GAP && cnt == CNT_LAST)) begin
                rd_addr_top <= top_of(iss_j, iss_s);
                rd_addr_bot <= top_of(iss_j, iss_s) | (LOG_N'(1) << iss_s);
                tw_addr     <= tw_of(iss_j, iss_s);
                stage_o     <= iss_s;
            end
        end
    end

    // Write-back pipe mirrors the PE latency; cleared on reset so aborted reads never write.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_dl <= '0;
            for (int k = 0; k < PIPE_LAT; k++) begin
                top_dl[k] <= '0;
                bot_dl[k] <= '0;
            end
        end else begin
            en_dl[0]  <= rd_en;
            top_dl[0] <= rd_addr_top;
            bot_dl[0] <= rd_addr_bot;
            for (int k = 1; k < PIPE_LAT; k++) begin
                en_dl[k]  <= en_dl[k-1];
                top_dl[k] <= top_dl[k-1];
                bot_dl[k] <= bot_dl[k-1];
            end
        end
    end

    assign wr_en       = en_dl[PIPE_LAT-1];
    assign wr_addr_top = top_dl[PIPE_LAT-1];
    assign wr_addr_bot = bot_dl[PIPE_LAT-1];

`ifdef NTT_STAGE_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles <= '0;
        end else if (state == IDLE && start) begin
            perf_cycles <= '0;
        end else if (busy) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ntt_stage_sched.sv
// tb/tb_ntt_stage_sched.sv - scoreboard bench for ntt_stage_sched (LOG_N=3, PIPE_LAT=4)
module tb_ntt_stage_sched;

    localparam int LOG_N    = 3;
    localparam int PIPE_LAT = 4;
    localparam int HALF     = 1 << (LOG_N - 1);
    localparam int RUN_LEN  = LOG_N * (HALF + PIPE_LAT) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             busy, done, rd_en, wr_en;
    logic [LOG_N-1:0] rd_addr_top, rd_addr_bot, wr_addr_top, wr_addr_bot;
    logic [LOG_N-2:0] tw_addr;
    logic [$clog2(LOG_N):0] stage_o;
`ifdef NTT_STAGE_SCHED_PERF_EN
    logic [31:0]      perf_cycles;
`endif

    ntt_stage_sched #(.LOG_N(LOG_N), .PIPE_LAT(PIPE_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr_top(rd_addr_top), .rd_addr_bot(rd_addr_bot),
        .tw_addr(tw_addr), .wr_en(wr_en), .wr_addr_top(wr_addr_top),
        .wr_addr_bot(wr_addr_bot),
`ifdef NTT_STAGE_SCHED_PERF_EN
        .perf_cycles(perf_cycles),
`endif
        .stage_o(stage_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int top;
        int bot;
        int tw;
        int stg;
    } ev_t;

    ev_t rd_q[$];
    ev_t wr_q[$];
    int  done_q[$];
    int  cyc = 0;
    int  passed = 0;
    int  total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic push_transform(input int c0);
        ev_t e;
        for (int s = 0; s < LOG_N; s++) begin
            for (int jj = 0; jj < HALF; jj++) begin
                int m;
                m     = 1 << s;
                e.cyc = c0 + 1 + s * (HALF + PIPE_LAT) + jj;
                e.top = (jj / m) * 2 * m + (jj % m);
                e.bot = e.top + m;
                e.tw  = (jj % m) * (HALF / m);
                e.stg = s;
                rd_q.push_back(e);
                e.cyc = e.cyc + PIPE_LAT;
                wr_q.push_back(e);
            end
        end
        done_q.push_back(c0 + RUN_LEN);
    endtask

    task automatic flush_after(input int lim);
        ev_t r[$];
        ev_t w[$];
        int  d[$];
        foreach (rd_q[i]) if (rd_q[i].cyc <= lim) r.push_back(rd_q[i]);
        foreach (wr_q[i]) if (wr_q[i].cyc <= lim) w.push_back(wr_q[i]);
        foreach (done_q[i]) if (done_q[i] <= lim) d.push_back(done_q[i]);
        rd_q = r;
        wr_q = w;
        done_q = d;
    endtask

    // Scoreboard: every strobe pops one expectation; overdue expectations are reported.
    always @(negedge clk) begin
        ev_t e;
        if (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
            total++;
            e = rd_q.pop_front();
            $display("FAIL rd_missing: expected rd at cycle %0d, now %0d", e.cyc, cyc);
        end
        if (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
            total++;
            e = wr_q.pop_front();
            $display("FAIL wr_missing: expected wr at cycle %0d, now %0d", e.cyc, cyc);
        end
        if (done_q.size() > 0 && done_q[0] < cyc) begin
            total++;
            $display("FAIL done_missing: expected done at cycle %0d, now %0d", done_q.pop_front(), cyc);
        end
        if (rd_en === 1'b1) begin
            total++;
            if (rd_q.size() == 0) begin
                $display("FAIL rd_unexpected: rd_en at cycle %0d, required none", cyc);
            end else begin
                e = rd_q.pop_front();
                if (e.cyc !== cyc || int'(rd_addr_top) !== e.top || int'(rd_addr_bot) !== e.bot ||
                    int'(tw_addr) !== e.tw || int'(stage_o) !== e.stg)
                    $display("FAIL rd_event: got cyc %0d (%0d,%0d) tw %0d st %0d, required cyc %0d (%0d,%0d) tw %0d st %0d",
                             cyc, rd_addr_top, rd_addr_bot, tw_addr, stage_o,
                             e.cyc, e.top, e.bot, e.tw, e.stg);
                else passed++;
            end
        end
        if (wr_en === 1'b1) begin
            total++;
            if (wr_q.size() == 0) begin
                $display("FAIL wr_unexpected: wr_en at cycle %0d, required none", cyc);
            end else begin
                e = wr_q.pop_front();
                if (e.cyc !== cyc || int'(wr_addr_top) !== e.top || int'(wr_addr_bot) !== e.bot)
                    $display("FAIL wr_event: got cyc %0d (%0d,%0d), required cyc %0d (%0d,%0d)",
                             cyc, wr_addr_top, wr_addr_bot, e.cyc, e.top, e.bot);
                else passed++;
            end
        end
        if (done === 1'b1) begin
            total++;
            if (done_q.size() == 0) begin
                $display("FAIL done_unexpected: done at cycle %0d, required none", cyc);
            end else if (done_q.pop_front() !== cyc) begin
                $display("FAIL done_cycle: done at cycle %0d, required a different cycle", cyc);
            end else begin
                passed++;
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        step();
        step();
        total++;
        if ({busy, done, rd_en, wr_en, rd_addr_top, rd_addr_bot, tw_addr, wr_addr_top,
             wr_addr_bot, stage_o} !== '0)
            $display("FAIL reset_outputs: got %b, required all zero",
                     {busy, done, rd_en, wr_en, rd_addr_top, rd_addr_bot, tw_addr,
                      wr_addr_top, wr_addr_bot, stage_o});
        else passed++;
    endtask

    task automatic check_drained(input string name);
        total++;
        if (rd_q.size() != 0 || wr_q.size() != 0 || done_q.size() != 0)
            $display("FAIL %s_drained: pending rd %0d wr %0d done %0d, required 0 0 0",
                     name, rd_q.size(), wr_q.size(), done_q.size());
        else passed++;
    endtask

    // Start in the very first cycle after reset release.
    task automatic test_single();
        int c0;
        reset = 1'b0;
        start = 1'b1;
        c0 = cyc;
        push_transform(c0);
        step();
        start = 1'b0;
        total++;
        if (busy !== 1'b1) $display("FAIL busy_rise: got %b, required 1", busy);
        else passed++;
        step_to(c0 + 5);
        total++;
        if (rd_en !== 1'b0 || rd_addr_top !== 3'd6 || rd_addr_bot !== 3'd7 || stage_o !== 3'd0)
            $display("FAIL gap_hold: got rd_en %b (%0d,%0d) st %0d, required 0 (6,7) st 0",
                     rd_en, rd_addr_top, rd_addr_bot, stage_o);
        else passed++;
        step_to(c0 + RUN_LEN);
        total++;
        if (busy !== 1'b1) $display("FAIL busy_fin: got %b, required 1", busy);
        else passed++;
        step();
        total++;
        if (busy !== 1'b0) $display("FAIL busy_idle: got %b, required 0", busy);
        else passed++;
`ifdef NTT_STAGE_SCHED_PERF_EN
        total++;
        if (perf_cycles !== 32'd25) $display("FAIL perf_cycles: got %0d, required 25", perf_cycles);
        else passed++;
`endif
        step_to(c0 + 32);
        check_drained("single");
    endtask

    task automatic test_reset_abort();
        int c0;
        c0 = cyc;
        start = 1'b1;
        push_transform(c0);
        step();
        start = 1'b0;
        step_to(c0 + 10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        flush_after(c0 + 10);
        total++;
        if ({busy, done, rd_en, wr_en, rd_addr_top, rd_addr_bot, tw_addr, wr_addr_top,
             wr_addr_bot, stage_o} !== '0)
            $display("FAIL abort_zero: got %b, required all zero",
                     {busy, done, rd_en, wr_en, rd_addr_top, rd_addr_bot, tw_addr,
                      wr_addr_top, wr_addr_bot, stage_o});
        else passed++;
        step_to(c0 + 12);
        start = 1'b1;
        push_transform(c0 + 12);
        step();
        start = 1'b0;
        step_to(c0 + 12 + 32);
        check_drained("abort");
    endtask

    task automatic test_start_held();
        int c0;
        c0 = cyc;
        start = 1'b1;
        push_transform(c0);
        push_transform(c0 + RUN_LEN + 1);
        step_to(c0 + 26);
        total++;
        if (busy !== 1'b0) $display("FAIL held_idle: got busy %b, required 0", busy);
        else passed++;
        step_to(c0 + 31);
        start = 1'b0;
        step_to(c0 + 58);
        check_drained("held");
    endtask

    // Starts mid-run and during FIN must be dropped, not queued.
    task automatic test_start_ignored();
        int c0;
        c0 = cyc;
        start = 1'b1;
        push_transform(c0);
        step();
        start = 1'b0;
        step_to(c0 + 3);
        start = 1'b1;
        step();
        start = 1'b0;
        step_to(c0 + RUN_LEN);
        start = 1'b1;
        step();
        start = 1'b0;
        step_to(c0 + 28);
        total++;
        if (busy !== 1'b0) $display("FAIL fin_start_ignored: got busy %b, required 0", busy);
        else passed++;
        step_to(c0 + 45);
        check_drained("ignored");
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_single();
        test_reset_abort();
        test_start_held();
        test_start_ignored();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
